io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the J1 I/O bus (mult/div/uart/dp_ram/timer decoder) between the J1 CPU and a second master (USB/DMA engine).
//  CPU has absolute priority and is never stalled; the second master (m1) uses a req/ack handshake.
//  m1 is granted only on cycles with no CPU strobe. If a CPU strobe hits an m1 read in flight, m1 is aborted and retried.
//  Sits between cpu0 and the chip-select decoder / read mux; bus_* replaces j1_io_* at the decoder.
// PARAMETERS
//  RD_LATENCY  1   cycles from bus_rd strobe to valid bus_din (1..4)
//  MAX_RETRY   15  CPU-preempted attempts before m1 transaction ends with error (1..255)
// PORTS
//  sys_clk_i     in   1   system clock, all logic on rising edge
//  sys_rst_i     in   1   synchronous reset, active-high
//  cpu_io_rd     in   1   CPU read strobe
//  cpu_io_wr     in   1   CPU write strobe
//  cpu_io_addr   in   16  CPU address
//  cpu_io_dout   in   16  CPU write data
//  cpu_io_din    out  16  CPU read data (= bus_din, combinational)
//  m1_req        in   1   m1 request; held with m1_wr/m1_addr/m1_wdata stable until m1_ack
//  m1_wr         in   1   1=write, 0=read
//  m1_addr       in   16  m1 address
//  m1_wdata      in   16  m1 write data
//  m1_ack        out  1   registered 1-cycle done pulse
//  m1_err        out  1   valid with m1_ack: 1=aborted after MAX_RETRY preemptions
//  m1_rdata      out  16  read data, updated only on successful read ack, held otherwise
//  bus_rd        out  1   shared read strobe
//  bus_wr        out  1   shared write strobe
//  bus_addr      out  16  shared address
//  bus_dout      out  16  shared write data
//  bus_din       in   16  shared read data from peripheral mux
// BEHAVIOUR
//  Reset: state=IDLE; m1_ack=0, m1_err=0, m1_rdata=0, retry_cnt=0, wait_cnt=0.
//  Reset mid-transaction abandons it: no ack issued, bus returns to idle.
//  Bus mux (combinational), cpu_act = cpu_io_rd|cpu_io_wr:
//   - cpu_act: bus_* = CPU fields, unconditionally, in any state.
//   - else if state==ISSUE: bus_addr=m1_addr, bus_dout=m1_wdata, bus_wr=m1_wr, bus_rd=~m1_wr.
//   - else if state==WAIT: bus_addr=m1_addr, bus_rd=bus_wr=0.
//   - else: all bus_* = 0.
//  FSM:
//   - IDLE: m1_req && !m1_ack -> ISSUE, retry_cnt=0. A request is never taken in the m1_ack cycle.
//   - ISSUE, cpu_act: stay, retry_cnt++.
//   - ISSUE, !cpu_act, write: strobe issued; next cycle m1_ack=1, m1_err=0, -> IDLE.
//   - ISSUE, !cpu_act, read: strobe issued; -> WAIT, wait_cnt=RD_LATENCY-1.
//   - WAIT, cpu_act: abort, -> ISSUE, retry_cnt++.
//   - WAIT, !cpu_act, wait_cnt!=0: wait_cnt--.
//   - WAIT, !cpu_act, wait_cnt==0: m1_rdata<=bus_din; next cycle m1_ack=1, m1_err=0; -> IDLE.
//  Retry limit: when retry_cnt reaches MAX_RETRY (on an increment), next cycle m1_ack=1, m1_err=1, -> IDLE.
//   Writes are never strobed on an aborted attempt.
//  Throughput:
//   - uncontended m1 write: ack 2 cycles after req sampled.
//   - uncontended m1 read: ack RD_LATENCY+2 cycles after req sampled.
//   - back-to-back period >= 3 cycles.
//  m1_req dropped before ack: undefined, master must not do it. CPU path adds zero latency.
// TESTING
//  1. Reset high 2 cycles, with m1_req=1 and CPU idle -> all outputs 0, no bus strobe during reset.
//  2. CPU idle; m1 write addr 16'h6904 data 16'h0041 -> one bus_wr cycle with those values, then m1_ack=1, m1_err=0.
//  3. CPU idle; m1 read 16'h7010, bus_din=16'hBEEF after RD_LATENCY -> m1_rdata=16'hBEEF, ack at RD_LATENCY+2.
//  4. CPU rd 16'h6702 in the m1 WAIT cycle -> bus shows CPU addr, m1 retried, final m1_rdata from the m1 access only.
//  5. CPU strobes every cycle for 20 cycles with m1_req pending -> no m1 strobe; ack with m1_err=1 after MAX_RETRY=15.
//  6. Assert sys_rst_i during m1 WAIT -> no ack; later new m1 request completes normally.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the J1 I/O bus between the J1 CPU (absolute priority, never
//   stalled) and a second master m1 (USB/DMA) that uses a req/ack handshake.
//   m1 only gets the bus on cycles with no CPU strobe. A CPU strobe that lands
//   on an m1 read in flight aborts it and the read is re-issued. After
//   MAX_RETRY preemptions m1 is released with an error.
//
// Ports
//   sys_clk_i, sys_rst_i        clock, synchronous active-high reset
//   cpu_io_rd/wr/addr/dout      CPU strobes, address and write data
//   cpu_io_din                  CPU read data (bus_din passed straight through)
//   m1_req/wr/addr/wdata        m1 request, held stable until m1_ack
//   m1_ack/err/rdata            registered done pulse, error flag, read data
//   bus_rd/wr/addr/dout         shared bus towards the chip-select decoder
//   bus_din                     shared read data from the peripheral mux
module io_bus_arbiter #(
    parameter int RD_LATENCY = 1,   // strobe-to-data cycles, 1..4
    parameter int MAX_RETRY  = 15   // preemptions before error, 1..255
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        cpu_io_rd,
    input  logic        cpu_io_wr,
    input  logic [15:0] cpu_io_addr,
    input  logic [15:0] cpu_io_dout,
    output logic [15:0] cpu_io_din,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] m1_rdata,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
    localparam logic [1:0] WAIT_INIT   = 2'(RD_LATENCY - 1);

    state_t      state;
    logic [7:0]  retry_cnt;
    logic [1:0]  wait_cnt;
    logic        cpu_act;
    logic [7:0]  retry_inc;
    logic        retry_hit;

    assign cpu_act    = cpu_io_rd | cpu_io_wr;
    assign retry_inc  = retry_cnt + 8'd1;
    // Limit is judged on the incremented value so the MAX_RETRY-th
    // preemption itself ends the transaction.
    assign retry_hit  = (retry_inc == RETRY_LIMIT);
    assign cpu_io_din = bus_din;

    // Bus mux: CPU always wins; m1 fields only drive the bus when CPU is idle.
    always_comb begin
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = 16'h0000;
        bus_dout = 16'h0000;
        if (cpu_act) begin
            bus_rd   = cpu_io_rd;
            bus_wr   = cpu_io_wr;
            bus_addr = cpu_io_addr;
            bus_dout = cpu_io_dout;
        end else begin
            case (state)
                ST_ISSUE: begin
                    bus_addr = m1_addr;
                    bus_dout = m1_wdata;
                    bus_wr   = m1_wr;
                    bus_rd   = ~m1_wr;
                end
                ST_WAIT: begin
                    // Keep the address steady for the decoder's read mux.
                    bus_addr = m1_addr;
                end
                default: begin
                    bus_rd = 1'b0;
                end
            endcase
        end
    end

    // m1 transaction FSM with registered ack/err/rdata.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state     <= ST_IDLE;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= 16'h0000;
            retry_cnt <= 8'd0;
            wait_cnt  <= 2'd0;
        end else begin
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The request is still high in the ack cycle; skip it so
                    // a completed transaction is not started twice.
                    if (m1_req && !m1_ack) begin
                        state     <= ST_ISSUE;
                        retry_cnt <= 8'd0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cpu_act) begin
                        retry_cnt <= retry_inc;
                        if (retry_hit) begin
                            m1_ack <= 1'b1;
                            m1_err <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end else if (m1_wr) begin
                        m1_ack <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cpu_act) begin
                        // CPU took the bus before our data arrived: re-issue.
                        retry_cnt <= retry_inc;
                        if (retry_hit) begin
                            m1_ack <= 1'b1;
                            m1_err <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end else if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        m1_rdata <= bus_din;
                        m1_ack   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
